// File: rtl/wb_pkg.sv
// wb_pkg: shared constants for the white-balance gain stage.
//   DATA_MAX / GAIN_UNITY  : saturation ceiling and the unity gain in Q2.8.
//   *_DEF                  : default widths used by wb_gain_stage parameters.
//   CH0..CH2, NUM_CH       : colour-plane indices.
package wb_pkg;

  localparam int unsigned DATA_W_DEF    = 12;
  localparam int unsigned GAIN_W_DEF    = 10;
  localparam int unsigned GAIN_FRAC_DEF = 8;
  localparam int unsigned STAT_W_DEF    = 36;

  localparam int unsigned DATA_MAX   = 4095;
  localparam int unsigned GAIN_UNITY = 256;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned CH0    = 0;
  localparam int unsigned CH1    = 1;
  localparam int unsigned CH2    = 2;

endpackage

// File: rtl/wb_gain_stage_if.sv
// wb_gain_stage_if: three-plane pixel stream in and out of the gain stage.
//   master : pixel source side (drives inpvalid/din0..2, observes outvalid/dout0..2)
//   slave  : gain stage side   (receives inpvalid/din0..2, drives outvalid/dout0..2)
interface wb_gain_stage_if #(
  parameter int unsigned DATA_W = 12
);
  logic              inpvalid;
  logic [DATA_W-1:0] din0;
  logic [DATA_W-1:0] din1;
  logic [DATA_W-1:0] din2;
  logic              outvalid;
  logic [DATA_W-1:0] dout0;
  logic [DATA_W-1:0] dout1;
  logic [DATA_W-1:0] dout2;

  modport master (
    output inpvalid, din0, din1, din2,
    input  outvalid, dout0, dout1, dout2
  );

  modport slave (
    input  inpvalid, din0, din1, din2,
    output outvalid, dout0, dout1, dout2
  );
endinterface

// File: rtl/wb_gain_mul.sv
// wb_gain_mul: one colour plane, pipeline stages S2 and S3.
//   S2: prod_q = din * gain (full DATA_W+GAIN_W width).
//   S3: dout_q = saturate((prod_q + half LSB) >> GAIN_FRAC), loaded only
//       when s2_valid is set, otherwise held.
// Ports: clk, rstn (sync, active-low), din/gain (S1 registers),
//        s2_valid (valid of the product currently in prod_q), dout.
module wb_gain_mul #(
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned GAIN_W    = 10,
  parameter int unsigned GAIN_FRAC = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] din,
  input  logic [GAIN_W-1:0] gain,
  input  logic              s2_valid,
  output logic [DATA_W-1:0] dout
);

  localparam int unsigned PROD_W = DATA_W + GAIN_W;
  localparam int unsigned RND_W  = PROD_W + 1 - GAIN_FRAC;
  localparam logic [PROD_W:0] HALF = (PROD_W+1)'(1) << (GAIN_FRAC - 1);

  logic [PROD_W-1:0] prod_d, prod_q;
  logic [PROD_W:0]   rnd;
  logic [RND_W-1:0]  r;
  logic [DATA_W-1:0] dout_d, dout_q;

  always_comb begin
    prod_d = PROD_W'(din) * PROD_W'(gain);
    rnd    = {1'b0, prod_q} + HALF;
    r      = rnd[PROD_W:GAIN_FRAC];
    dout_d = dout_q;
    if (s2_valid) begin
      // any bit above DATA_W means the rounded result exceeds the plane max
      dout_d = (|r[RND_W-1:DATA_W]) ? '1 : r[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      prod_q <= '0;
      dout_q <= '0;
    end else begin
      prod_q <= prod_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/wb_gain_stage.sv
// wb_gain_stage: per-channel white-balance gain, latency 3, 1 pixel/clk.
//   clk, rstn           : clock, synchronous active-low reset
//   frame_start         : frame boundary pulse; applies pending gains
//   px (slave)          : inpvalid/din0..2 in, outvalid/dout0..2 out
//   gain_wr/sel/data    : gain write port (sel 3 ignored), Q2.8 gains
//   gain_pending        : a written gain waits for the next frame_start
//   stat_sum0..2        : per-frame pre-gain input sums (WB_STATS_EN)
//   stat_valid          : one-cycle update pulse for stat_sum (WB_STATS_EN)
// Optional feature macro: WB_STATS_EN (stat outputs tie to 0 when undefined).
module wb_gain_stage
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned GAIN_W    = GAIN_W_DEF,
  parameter int unsigned GAIN_FRAC = GAIN_FRAC_DEF,
  parameter int unsigned STAT_W    = STAT_W_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               frame_start,
  wb_gain_stage_if.slave     px,
  input  logic               gain_wr,
  input  logic [1:0]         gain_sel,
  input  logic [GAIN_W-1:0]  gain_data,
  output logic               gain_pending,
  output logic [STAT_W-1:0]  stat_sum0,
  output logic [STAT_W-1:0]  stat_sum1,
  output logic [STAT_W-1:0]  stat_sum2,
  output logic               stat_valid
);

  logic [DATA_W-1:0] din_a  [NUM_CH];
  logic [DATA_W-1:0] dout_a [NUM_CH];

  assign din_a[CH0] = px.din0;
  assign din_a[CH1] = px.din1;
  assign din_a[CH2] = px.din2;

  // Gain double buffer
  logic [GAIN_W-1:0] pend_d [NUM_CH];
  logic [GAIN_W-1:0] pend_q [NUM_CH];
  logic [GAIN_W-1:0] act_d  [NUM_CH];
  logic [GAIN_W-1:0] act_q  [NUM_CH];
  logic              gain_pending_d, gain_pending_q;

  // S1 registers and valid pipe
  logic [DATA_W-1:0] s1_din_d  [NUM_CH];
  logic [DATA_W-1:0] s1_din_q  [NUM_CH];
  logic [GAIN_W-1:0] s1_gain_d [NUM_CH];
  logic [GAIN_W-1:0] s1_gain_q [NUM_CH];
  logic              s1_valid_d, s1_valid_q;
  logic              s2_valid_d, s2_valid_q;
  logic              outvalid_d, outvalid_q;

  always_comb begin
    pend_d         = pend_q;
    act_d          = act_q;
    gain_pending_d = gain_pending_q;
    // apply reads the old pending values; a same-cycle write then lands in
    // pending and re-arms gain_pending, so the write takes precedence here
    if (frame_start) begin
      act_d          = pend_q;
      gain_pending_d = 1'b0;
    end
    if (gain_wr && (gain_sel != 2'd3)) begin
      pend_d[gain_sel] = gain_data;
      gain_pending_d   = 1'b1;
    end

    // S1 captures act_q, i.e. the gains in force before any same-cycle apply
    s1_din_d   = din_a;
    s1_gain_d  = act_q;
    s1_valid_d = px.inpvalid;
    s2_valid_d = s1_valid_q;
    outvalid_d = s2_valid_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pend_q         <= '{default: GAIN_W'(GAIN_UNITY)};
      act_q          <= '{default: GAIN_W'(GAIN_UNITY)};
      gain_pending_q <= 1'b0;
      s1_din_q       <= '{default: '0};
      s1_gain_q      <= '{default: '0};
      s1_valid_q     <= 1'b0;
      s2_valid_q     <= 1'b0;
      outvalid_q     <= 1'b0;
    end else begin
      pend_q         <= pend_d;
      act_q          <= act_d;
      gain_pending_q <= gain_pending_d;
      s1_din_q       <= s1_din_d;
      s1_gain_q      <= s1_gain_d;
      s1_valid_q     <= s1_valid_d;
      s2_valid_q     <= s2_valid_d;
      outvalid_q     <= outvalid_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    wb_gain_mul #(
      .DATA_W    (DATA_W),
      .GAIN_W    (GAIN_W),
      .GAIN_FRAC (GAIN_FRAC)
    ) u_mul (
      .clk      (clk),
      .rstn     (rstn),
      .din      (s1_din_q[g]),
      .gain     (s1_gain_q[g]),
      .s2_valid (s2_valid_q),
      .dout     (dout_a[g])
    );
  end

  assign gain_pending = gain_pending_q;
  assign px.outvalid  = outvalid_q;
  assign px.dout0     = dout_a[CH0];
  assign px.dout1     = dout_a[CH1];
  assign px.dout2     = dout_a[CH2];

`ifdef WB_STATS_EN
  logic [STAT_W-1:0] acc_d  [NUM_CH];
  logic [STAT_W-1:0] acc_q  [NUM_CH];
  logic [STAT_W-1:0] acc_in [NUM_CH];
  logic [STAT_W-1:0] sum_d  [NUM_CH];
  logic [STAT_W-1:0] sum_q  [NUM_CH];
  logic [STAT_W:0]   add;
  logic              stat_valid_d, stat_valid_q;

  always_comb begin
    acc_d        = acc_q;
    acc_in       = acc_q;
    sum_d        = sum_q;
    add          = '0;
    stat_valid_d = frame_start;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      // acc_in is the accumulator including this cycle's pixel, saturating
      add = {1'b0, acc_q[i]} + (STAT_W+1)'(din_a[i]);
      if (px.inpvalid) begin
        acc_in[i] = add[STAT_W] ? '1 : add[STAT_W-1:0];
      end
      if (frame_start) begin
        sum_d[i] = acc_in[i];
        acc_d[i] = px.inpvalid ? STAT_W'(din_a[i]) : '0;
      end else begin
        acc_d[i] = acc_in[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_q        <= '{default: '0};
      sum_q        <= '{default: '0};
      stat_valid_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      sum_q        <= sum_d;
      stat_valid_q <= stat_valid_d;
    end
  end

  assign stat_sum0  = sum_q[CH0];
  assign stat_sum1  = sum_q[CH1];
  assign stat_sum2  = sum_q[CH2];
  assign stat_valid = stat_valid_q;
`else
  assign stat_sum0  = '0;
  assign stat_sum1  = '0;
  assign stat_sum2  = '0;
  assign stat_valid = 1'b0;
`endif

endmodule

// File: tb/tb_wb_gain_stage.sv
// tb_wb_gain_stage: directed-vector bench for wb_gain_stage with
// hand-computed expected outputs. Honours WB_STATS_EN like the design.
module tb_wb_gain_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        frame_start;
  logic        gain_wr;
  logic [1:0]  gain_sel;
  logic [9:0]  gain_data;
  logic        gain_pending;
  logic [35:0] stat_sum0, stat_sum1, stat_sum2;
  logic        stat_valid;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  wb_gain_stage_if #(.DATA_W(12)) px ();

  wb_gain_stage #(
    .DATA_W    (12),
    .GAIN_W    (10),
    .GAIN_FRAC (8),
    .STAT_W    (36)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .frame_start  (frame_start),
    .px           (px.slave),
    .gain_wr      (gain_wr),
    .gain_sel     (gain_sel),
    .gain_data    (gain_data),
    .gain_pending (gain_pending),
    .stat_sum0    (stat_sum0),
    .stat_sum1    (stat_sum1),
    .stat_sum2    (stat_sum2),
    .stat_valid   (stat_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // advance one rising edge; sample 1 ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input logic v, input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
    px.inpvalid = v;
    px.din0     = a;
    px.din1     = b;
    px.din2     = c;
  endtask

  // single pixel, then wait until it reaches the output (3 edges)
  task automatic send_pix(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
    set_pix(1'b1, a, b, c);
    tick();
    set_pix(1'b0, 12'd0, 12'd0, 12'd0);
    tick();
    tick();
    check_eq("sp_outvalid", px.outvalid, 1'b1);
  endtask

  task automatic wr_gain(input logic [1:0] sel, input logic [9:0] val);
    gain_wr   = 1'b1;
    gain_sel  = sel;
    gain_data = val;
    tick();
    gain_wr   = 1'b0;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0; frame_start = 1'b0; gain_wr = 1'b0; gain_sel = 2'd0; gain_data = '0;
    set_pix(1'b0, 12'd0, 12'd0, 12'd0);
    tick();
    tick();
    check_eq("rst_outvalid", px.outvalid, 1'b0);
    check_eq("rst_dout0", px.dout0, 12'd0);
    check_eq("rst_dout2", px.dout2, 12'd0);
    check_eq("rst_pending", gain_pending, 1'b0);
    check_eq("rst_stat_sum0", stat_sum0, 36'd0);
    check_eq("rst_stat_valid", stat_valid, 1'b0);
    rstn = 1'b1;

    // unity gain, latency check
    set_pix(1'b1, 12'd100, 12'd2000, 12'd4095);
    tick();
    set_pix(1'b0, 12'd0, 12'd0, 12'd0);
    tick();
    check_eq("lat_early_outvalid", px.outvalid, 1'b0);
    tick();
    check_eq("unity_outvalid", px.outvalid, 1'b1);
    check_eq("unity_dout0", px.dout0, 12'd100);
    check_eq("unity_dout1", px.dout1, 12'd2000);
    check_eq("unity_dout2", px.dout2, 12'd4095);
    tick();
    check_eq("unity_gap_outvalid", px.outvalid, 1'b0);
    check_eq("unity_hold_dout0", px.dout0, 12'd100);

    // write without apply
    wr_gain(2'd0, 10'd512);
    check_eq("wr_pending", gain_pending, 1'b1);
    send_pix(12'd100, 12'd2000, 12'd4095);
    check_eq("noapply_dout0", px.dout0, 12'd100);
    check_eq("noapply_pending", gain_pending, 1'b1);
    pulse_fs();
    check_eq("apply_pending", gain_pending, 1'b0);
    send_pix(12'd100, 12'd0, 12'd0);
    check_eq("x2_dout0", px.dout0, 12'd200);
    check_eq("x2_dout1", px.dout1, 12'd0);

    // 1.5x rounding and max-gain saturation
    wr_gain(2'd1, 10'd384);
    wr_gain(2'd2, 10'd1023);
    pulse_fs();
    send_pix(12'd100, 12'd3, 12'd2000);
    check_eq("g512_dout0", px.dout0, 12'd200);
    check_eq("g384_round_dout1", px.dout1, 12'd5);
    check_eq("g1023_sat_dout2", px.dout2, 12'd4095);
    send_pix(12'd4095, 12'd4095, 12'd1024);
    check_eq("g512_sat_dout0", px.dout0, 12'd4095);
    check_eq("g384_sat_dout1", px.dout1, 12'd4095);
    check_eq("g1023_1024_dout2", px.dout2, 12'd4092);
    send_pix(12'd0, 12'd1, 12'd1026);
    check_eq("g512_zero_dout0", px.dout0, 12'd0);
    check_eq("g384_one_dout1", px.dout1, 12'd2);
    check_eq("g1023_1026_dout2", px.dout2, 12'd4095);

    // zero gain
    wr_gain(2'd0, 10'd0);
    pulse_fs();
    send_pix(12'd100, 12'd0, 12'd0);
    check_eq("g0_dout0", px.dout0, 12'd0);

    // write coinciding with frame_start: apply uses old pending (512)
    wr_gain(2'd0, 10'd512);
    gain_wr = 1'b1; gain_sel = 2'd0; gain_data = 10'd128; frame_start = 1'b1;
    tick();
    gain_wr = 1'b0; frame_start = 1'b0;
    check_eq("coinc_pending", gain_pending, 1'b1);
    send_pix(12'd100, 12'd0, 12'd0);
    check_eq("coinc_dout0", px.dout0, 12'd200);

    // pixel in frame_start cycle uses pre-update gain, next pixel uses 128
    frame_start = 1'b1;
    set_pix(1'b1, 12'd100, 12'd0, 12'd0);
    tick();
    frame_start = 1'b0;
    tick();
    set_pix(1'b0, 12'd0, 12'd0, 12'd0);
    tick();
    check_eq("fs_pix_outvalid", px.outvalid, 1'b1);
    check_eq("fs_pix_dout0", px.dout0, 12'd200);
    tick();
    check_eq("post_fs_outvalid", px.outvalid, 1'b1);
    check_eq("post_fs_dout0", px.dout0, 12'd50);
    check_eq("post_fs_pending", gain_pending, 1'b0);

    // gain_sel 3 ignored
    wr_gain(2'd3, 10'd7);
    check_eq("sel3_pending", gain_pending, 1'b0);
    pulse_fs();
    send_pix(12'd100, 12'd0, 12'd0);
    check_eq("sel3_dout0", px.dout0, 12'd50);

    // valid gaps propagate, dout holds
    set_pix(1'b1, 12'd40, 12'd0, 12'd0);
    tick();
    set_pix(1'b0, 12'd999, 12'd999, 12'd999);
    tick();
    set_pix(1'b1, 12'd80, 12'd0, 12'd0);
    tick();
    check_eq("alt0_outvalid", px.outvalid, 1'b1);
    check_eq("alt0_dout0", px.dout0, 12'd20);
    set_pix(1'b0, 12'd0, 12'd0, 12'd0);
    tick();
    check_eq("alt1_outvalid", px.outvalid, 1'b0);
    check_eq("alt1_hold_dout0", px.dout0, 12'd20);
    tick();
    check_eq("alt2_outvalid", px.outvalid, 1'b1);
    check_eq("alt2_dout0", px.dout0, 12'd40);
    tick();
    check_eq("alt3_outvalid", px.outvalid, 1'b0);

    // reset mid-stream discards in-flight pixels
    set_pix(1'b1, 12'd200, 12'd0, 12'd0);
    tick();
    set_pix(1'b1, 12'd300, 12'd0, 12'd0);
    tick();
    set_pix(1'b0, 12'd0, 12'd0, 12'd0);
    rstn = 1'b0;
    tick();
    check_eq("midrst_outvalid", px.outvalid, 1'b0);
    check_eq("midrst_dout0", px.dout0, 12'd0);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("midrst_no_stale", px.outvalid, 1'b0);
    end
    send_pix(12'd100, 12'd0, 12'd0);
    check_eq("midrst_unity_dout0", px.dout0, 12'd100);

`ifdef WB_STATS_EN
    pulse_fs();
    check_eq("st_flush_valid", stat_valid, 1'b1);
    check_eq("st_flush_sum0", stat_sum0, 36'd100);
    tick();
    check_eq("st_valid_pulse", stat_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      set_pix(1'b1, 12'd10, 12'd1, 12'd2);
      tick();
    end
    set_pix(1'b0, 12'd0, 12'd0, 12'd0);
    pulse_fs();
    check_eq("st_frame_valid", stat_valid, 1'b1);
    check_eq("st_frame_sum0", stat_sum0, 36'd40);
    check_eq("st_frame_sum1", stat_sum1, 36'd4);
    check_eq("st_frame_sum2", stat_sum2, 36'd8);
    tick();
    check_eq("st_frame_valid_low", stat_valid, 1'b0);
    check_eq("st_frame_sum0_hold", stat_sum0, 36'd40);
    set_pix(1'b1, 12'd5, 12'd0, 12'd0);
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    set_pix(1'b0, 12'd0, 12'd0, 12'd0);
    check_eq("st_incl_fs_sum0", stat_sum0, 36'd10);
    pulse_fs();
    check_eq("st_restart_sum0", stat_sum0, 36'd5);
`else
    pulse_fs();
    check_eq("st_off_sum0", stat_sum0, 36'd0);
    check_eq("st_off_valid", stat_valid, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
